div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 153 +++++++++++++++
 tb/tb_div_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// RV32M iterative divider: DIV/DIVU/REM/REMU via 32 radix-2 restoring steps,
// with single-cycle handling of divide-by-zero and signed overflow.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [4:0]  rd_in,
    input  logic        kill,
    output logic        busy,
    output logic        done,
    output logic        reg_write,
    output logic [4:0]  rd_out,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic        is_rem;
    logic        neg_q;
    logic        neg_r;
    logic [4:0]  rd_q;
    logic [4:0]  cnt;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvsr;

    // Operand decode for an incoming request.
    logic        sgn;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        overflow;
    logic [31:0] special_val;

    always_comb begin
        sgn         = ~op[0];
        a_neg       = sgn & rs1_val[31];
        b_neg       = sgn & rs2_val[31];
        a_mag       = a_neg ? -rs1_val : rs1_val;
        b_mag       = b_neg ? -rs2_val : rs2_val;
        div_zero    = (rs2_val == 32'd0);
        overflow    = sgn && (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);
        special_val = 32'd0;
        if (div_zero)
            special_val = op[1] ? rs1_val : 32'hFFFF_FFFF;
        else if (overflow)
            special_val = op[1] ? 32'd0 : 32'h8000_0000;
    end

    // One restoring step; bit 32 of diff is the borrow that decides the quotient bit.
    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] fin_val;

    always_comb begin
        rem_shift = {rem, quo[31]};
        diff      = rem_shift - {1'b0, dvsr};
        if (!diff[32]) begin
            rem_next = diff[31:0];
            quo_next = {quo[30:0], 1'b1};
        end else begin
            rem_next = rem_shift[31:0];
            quo_next = {quo[30:0], 1'b0};
        end
        if (is_rem)
            fin_val = neg_r ? -rem_next : rem_next;
        else
            fin_val = neg_q ? -quo_next : quo_next;
    end

    assign reg_write = done;

    // NOTE: every state register here is assigned with <= so all of them update
    // together from values sampled before the edge; a blocking = would leak
    // freshly written values into later statements of the same block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            rd_out <= 5'd0;
            result <= 32'd0;
            is_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            rd_q   <= 5'd0;
            cnt    <= 5'd0;
            quo    <= 32'd0;
            rem    <= 32'd0;
            dvsr   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !kill) begin
                        is_rem <= op[1];
                        rd_q   <= rd_in;
                        busy   <= 1'b1;
                        if (div_zero || overflow) begin
                            result <= special_val;
                            rd_out <= rd_in;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            quo   <= a_mag;
                            rem   <= 32'd0;
                            dvsr  <= b_mag;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                            cnt   <= 5'd0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (kill) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        quo <= quo_next;
                        rem <= rem_next;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            result <= fin_val;
                            rd_out <= rd_q;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: table of ops with hand-computed results,
// plus sequences for ignored start, kill, and asynchronous reset mid-divide.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        kill;
    logic        busy;
    logic        done;
    logic        reg_write;
    logic [4:0]  rd_out;
    logic [31:0] result;

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .rd_in     (rd_in),
        .kill      (kill),
        .busy      (busy),
        .done      (done),
        .reg_write (reg_write),
        .rd_out    (rd_out),
        .result    (result)
    );

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    // Independent reference using the language's own division operators.
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            OP_DIV:  return $signed(a) / $signed(b);
            OP_REM:  return $signed(a) % $signed(b);
            OP_DIVU: return a / b;
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic drive_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        rs1_val = a;
        rs2_val = b;
        rd_in   = rd;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Issues one divide and watches cycles 1..lat+1 (cycle 0 is the start cycle).
    task automatic do_div(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp, input int lat);
        int          done_at;
        int          done_cnt;
        logic        busy_bad;
        logic        rw_bad;
        logic [31:0] res;
        logic [4:0]  rdo;
        done_at  = 0;
        done_cnt = 0;
        busy_bad = 1'b0;
        rw_bad   = 1'b0;
        res      = 32'd0;
        rdo      = 5'd0;
        drive_start(o, a, b, rd);
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = c;
                    res     = result;
                    rdo     = rd_out;
                end
            end
            if (reg_write !== done) rw_bad = 1'b1;
            if (c <= lat && busy !== 1'b1) busy_bad = 1'b1;
            if (c == lat + 1 && busy !== 1'b0) busy_bad = 1'b1;
        end
        check({name, "_done_cycle"}, done_at, lat);
        check({name, "_done_count"}, done_cnt, 1);
        check({name, "_result"}, res, exp);
        check({name, "_rd_out"}, rdo, rd);
        check({name, "_busy_bad"}, busy_bad, 1'b0);
        check({name, "_regwrite_bad"}, rw_bad, 1'b0);
    endtask

    initial begin
        int          done_at;
        logic [31:0] res;
        logic [4:0]  rdo;
        logic [31:0] pool[4];
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  ro;

        rst = 1'b1; start = 1'b0; op = 2'b00; rs1_val = 32'd0; rs2_val = 32'd0; rd_in = 5'd0; kill = 1'b0;
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_reg_write", reg_write, 1'b0);
        check("reset_rd_out", rd_out, 5'd0);
        check("reset_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        vecs.push_back('{OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         33});
        vecs.push_back('{OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd1,  32'hFFFF_FFFD,  33});
        vecs.push_back('{OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd2,  32'hFFFF_FFFF,  33});
        vecs.push_back('{OP_REMU, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'd1,          33});
        vecs.push_back('{OP_DIVU, 32'd5,          32'd0,          5'd4,  32'hFFFF_FFFF,  1});
        vecs.push_back('{OP_REMU, 32'd5,          32'd0,          5'd6,  32'd5,          1});
        vecs.push_back('{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'h8000_0000,  1});
        vecs.push_back('{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'd0,          1});
        vecs.push_back('{OP_DIV,  32'd7,          32'hFFFF_FFFE,  5'd9,  32'hFFFF_FFFD,  33});
        vecs.push_back('{OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd10, 32'd1,          33});
        vecs.push_back('{OP_DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFE,  5'd11, 32'd4,          33});
        vecs.push_back('{OP_REM,  32'hFFFF_FFF8,  32'd3,          5'd12, 32'hFFFF_FFFE,  33});
        vecs.push_back('{OP_REM,  32'hFFFF_FFF8,  32'hFFFF_FFFE,  5'd13, 32'd0,          33});
        vecs.push_back('{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'd0,          33});
        vecs.push_back('{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'h8000_0000,  33});
        vecs.push_back('{OP_DIV,  32'h8000_0000,  32'd3,          5'd16, 32'hD555_5556,  33});
        vecs.push_back('{OP_REM,  32'h8000_0000,  32'd3,          5'd17, 32'hFFFF_FFFE,  33});
        vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF,  32'h10,         5'd18, 32'h0FFF_FFFF,  33});
        vecs.push_back('{OP_REMU, 32'hFFFF_FFFF,  32'h10,         5'd19, 32'hF,          33});
        vecs.push_back('{OP_DIV,  32'hFFFF_FFFF,  32'd0,          5'd20, 32'hFFFF_FFFF,  1});
        vecs.push_back('{OP_REM,  32'hFFFF_FFFF,  32'd0,          5'd21, 32'hFFFF_FFFF,  1});
        vecs.push_back('{OP_DIV,  32'd0,          32'd5,          5'd22, 32'd0,          33});
        vecs.push_back('{OP_DIV,  32'h8000_0000,  32'd1,          5'd23, 32'h8000_0000,  33});

        foreach (vecs[i])
            do_div($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat);

        // Random operands drawn partly from boundary values, checked against the reference.
        pool[0] = 32'd0; pool[1] = 32'd1; pool[2] = 32'hFFFF_FFFF; pool[3] = 32'h8000_0000;
        for (int i = 0; i < 12; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
            do_div($sformatf("rnd%0d", i), ro, ra, rb, 5'(i + 1), ref_div(ro, ra, rb), ref_lat(ro, ra, rb));
        end

        // A start while busy must not disturb the running divide.
        drive_start(OP_DIVU, 32'd100, 32'd7, 5'd5);
        done_at = 0; res = 32'd0; rdo = 5'd0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (done && done_at == 0) begin
                done_at = c; res = result; rdo = rd_out;
            end
            if (c == 10) begin
                start = 1'b1; op = OP_DIV; rs1_val = 32'd999; rs2_val = 32'd3; rd_in = 5'd9;
            end
            if (c == 11) start = 1'b0;
        end
        check("ignore_start_done_cycle", done_at, 33);
        check("ignore_start_result", res, 32'd14);
        check("ignore_start_rd_out", rdo, 5'd5);

        // kill mid-divide, then a fresh start in the very next cycle.
        drive_start(OP_DIVU, 32'd100, 32'd7, 5'd30);
        done_at = 0; res = 32'd0; rdo = 5'd0;
        for (int c = 1; c <= 46; c++) begin
            @(negedge clk);
            if (done && done_at == 0) begin
                done_at = c; res = result; rdo = rd_out;
            end
            if (c == 10) kill = 1'b1;
            if (c == 11) begin
                check("kill_busy_low", busy, 1'b0);
                kill = 1'b0;
                start = 1'b1; op = OP_DIVU; rs1_val = 32'd50; rs2_val = 32'd5; rd_in = 5'd3;
            end
            if (c == 12) start = 1'b0;
        end
        check("kill_restart_done_cycle", done_at, 44);
        check("kill_restart_result", res, 32'd10);
        check("kill_restart_rd_out", rdo, 5'd3);

        // kill together with start in IDLE: not accepted.
        @(negedge clk);
        start = 1'b1; kill = 1'b1; op = OP_DIVU; rs1_val = 32'd9; rs2_val = 32'd0; rd_in = 5'd4;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("kill_start_busy", busy, 1'b0);
        check("kill_start_done", done, 1'b0);
        check("kill_start_result_held", result, 32'd10);

        // Asynchronous reset in the middle of a divide.
        drive_start(OP_DIVU, 32'd1000, 32'd3, 5'd7);
        for (int c = 1; c <= 15; c++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_reg_write", reg_write, 1'b0);
        check("arst_rd_out", rd_out, 5'd0);
        check("arst_result", result, 32'd0);
        #6 rst = 1'b0;
        done_at = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done && done_at == 0) done_at = c;
        end
        check("arst_no_done", done_at, 0);

        do_div("post_reset", OP_REMU, 32'd1000, 32'd3, 5'd27, 32'd1, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
